// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the serial chunk adder.
// Sizing functions are evaluated at elaboration time by the top module.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The chunk index counter is never narrower than one bit, even when N == 1.
  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// master = operand source plus result consumer, slave = the adder.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             c_in,
  output logic [CHUNK-1:0] s_c,
  output logic             c_msb_in,
  output logic             c_out
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a_c[i]),
      .b  (b_c[i]),
      .ci (w_c[i]),
      .s  (s_c[i]),
      .co (w_c[i+1])
    );
  end

  assign c_msb_in = w_c[CHUNK-1];
  assign c_out    = w_c[CHUNK];
endmodule

// File: rtl/full_adder.sv
// The team's 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH bits processed CHUNK bits per clock
// through one reused chunk_adder, with the carry registered between chunks.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_chunk_adder_if.slave  bus
);
  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CHUNK-1:0] w_s_c;
  logic             w_c_msb_in;
  logic             w_c_out;
  logic             w_last;

  assign w_last = (r_k == CW'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_c      (r_a[int'(r_k)*CHUNK +: CHUNK]),
    .b_c      (r_b[int'(r_k)*CHUNK +: CHUNK]),
    .c_in     (r_carry),
    .s_c      (w_s_c),
    .c_msb_in (w_c_msb_in),
    .c_out    (w_c_out)
  );

  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1, so cin is overridden by sub.
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub | bus.cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_k)*CHUNK +: CHUNK] <= w_s_c;
          r_carry <= w_c_out;
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_cout      <= w_c_out;
            r_ovf       <= w_c_msb_in ^ w_c_out;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder (WIDTH=8/CHUNK=2) plus a 32-bit
// sweep over CHUNK = 1, 8, 32 against an independent arithmetic model.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst8_n;
  logic rst32_n;
  logic sweep_go;
  logic [2:0] sweep_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- WIDTH=8, CHUNK=2 ----------------
  serial_chunk_adder_if #(.WIDTH(8)) bus8 ();

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (bus8)
  );

  // Present operands, wait for acceptance, then return with the DUT in RUN
  // (sampled 1 time unit after the accepting edge).
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    int g;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.sub = sb; bus8.in_valid = 1'b1;
    g = 0;
    while (!bus8.in_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) check("accept8 timeout", 0, 1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release8(input string tag);
    @(negedge clk); bus8.out_ready = 1'b1;
    @(posedge clk); #1; bus8.out_ready = 1'b0;
    check({tag, " idle out_valid"}, bus8.out_valid, 0);
    check({tag, " idle in_ready"}, bus8.in_ready, 1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb,
                     input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    accept8(a, b, ci, sb);
    wait_valid8(lat);
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, bus8.sum, e_sum);
    check({tag, " cout"}, bus8.cout, e_cout);
    check({tag, " ovf"}, bus8.ovf, e_ovf);
    release8(tag);
  endtask

  // ---------------- WIDTH=32 sweep ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
    localparam int NN = 32 / CH;

    serial_chunk_adder_if #(.WIDTH(32)) bus ();

    serial_chunk_adder #(.WIDTH(32), .CHUNK(CH)) dut (
      .clk   (clk),
      .rst_n (rst32_n),
      .bus   (bus)
    );

    initial begin
      logic [31:0] a, b, bb;
      logic        ci, sb;
      logic [32:0] full;
      logic        e_ovf;
      int          lat, g;
      string       pfx;
      pfx = $sformatf("w32c%0d", CH);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 200; i++) begin
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
        sb = i[0];
        if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h1; end
        if (i == 1) begin a = 32'h8000_0000; b = 32'h1; end
        if (i == 3) begin a = 32'h1234_5678; b = 32'h1234_5678; end
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb; bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) check({pfx, " accept timeout"}, 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        bb    = sb ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb | ci)};
        e_ovf = (a[31] == bb[31]) && (full[31] != a[31]);
        check({pfx, " latency"}, lat, NN);
        check({pfx, " sum"}, bus.sum, full[31:0]);
        check({pfx, " cout"}, bus.cout, full[32]);
        check({pfx, " ovf"}, bus.ovf, e_ovf);
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
      end
      sweep_done[gi] = 1'b1;
    end
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int lat;
    rst8_n = 1'b0; rst32_n = 1'b0; sweep_go = 1'b0; sweep_done = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;

    #12;
    check("reset in_ready", bus8.in_ready, 1);
    check("reset out_valid", bus8.out_valid, 0);
    check("reset sum", bus8.sum, 0);
    check("reset cout", bus8.cout, 0);
    check("reset ovf", bus8.ovf, 0);
    @(negedge clk); rst8_n = 1'b1; rst32_n = 1'b1;
    sweep_go = 1'b1;

    op8("add 3C+05+1", 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    op8("add 7F+01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add FF+01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("sub 05-07",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub 80-01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub 07-07",   8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure with operands disturbed during RUN.
    accept8(8'h12, 8'h34, 1'b0, 1'b0);
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus8.sub = ~bus8.sub; bus8.cin = ~bus8.cin;
      @(posedge clk); #1; lat++;
    end
    check("bp latency", lat, 4);
    check("bp sum", bus8.sum, 8'h46);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold out_valid", bus8.out_valid, 1);
      check("bp hold sum", bus8.sum, 8'h46);
      check("bp hold in_ready", bus8.in_ready, 0);
    end
    check("bp hold cout", bus8.cout, 0);
    check("bp hold ovf", bus8.ovf, 0);
    release8("bp");

    // Asynchronous reset in the second RUN cycle.
    accept8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst8_n = 1'b0;
    #1;
    check("rst out_valid", bus8.out_valid, 0);
    check("rst sum", bus8.sum, 0);
    check("rst in_ready", bus8.in_ready, 1);
    @(negedge clk); rst8_n = 1'b1;
    op8("post-rst 10+20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    for (int i = 0; i < 20000 && sweep_done != 3'b111; i++) @(posedge clk);
    check("sweep done", sweep_done, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle parametrised adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock, with a registered carry between chunks. It extends the team's single-bit adder cell into a word-level arithmetic unit. Area is traded for latency, and there is a valid/ready handshake on both sides. It sits between operand registers and the result bus in datapaths where a full-width carry chain would not close timing.

## Interface
Parameters:
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a−b (a + ~b + 1).
- out_valid  out  1  result held stable.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For sub=1 this means no-borrow (1 ⇔ a ≥ b unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/CHUNK chunk steps. Chunk index counter is max(1,$clog2(N)) bits wide.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b (inverted if sub) and the initial carry (1 if sub, else cin). Clear the counter and go to RUN.
- RUN:
  - Each cycle, add chunk k of the latched A and B plus the carry register.
  - Write the CHUNK result bits into sum[k*CHUNK +: CHUNK], update the carry register and increment k.
  - On the step where k==N−1, also record ovf and cout, then go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid there is ignored; the source must hold it.
- out_valid=0 outside DONE. out_ready is ignored outside DONE.
- Operands a, b, cin and sub are sampled only at acceptance. Later changes have no effect.
- Reset, including mid-RUN or in DONE:
  - State goes to IDLE and the operation is discarded; no partial result is ever flagged valid.
  - Outputs reset to: in_ready=1 (asserted during and after reset), out_valid=0, sum=0, cout=0, ovf=0.
- Wrap-around: sum is modulo 2^WIDTH. Overflow is reported only through cout and ovf.

## Timing
- Accept at edge t. Chunks are computed in cycles t+1 … t+N. out_valid rises after edge t+N.
- Latency from acceptance to out_valid is N cycles.
- If out_ready is high at the first DONE cycle: handshake at edge t+N+1, in_ready=1 in the next cycle, next accept at edge t+N+2 at the earliest. Peak throughput is one op per N+2 cycles.
- out_valid holds indefinitely while out_ready=0, with sum, cout and ovf unchanged.
- CHUNK=WIDTH (N=1) is legal: one RUN cycle.
- All outputs are registered. There is no combinational path from inputs to outputs except none: in_ready is a function of state only.

## Structure
- Package adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a constant function computing N and the counter width;
  - an elaboration check that WIDTH%CHUNK==0.
- Sub-module chunk_adder: a combinational CHUNK-bit ripple adder built from the existing 1-bit adder cell.
  - Inputs: a_c, b_c, c_in.
  - Outputs: s_c, c_msb_in (carry into top bit, for ovf), c_out.
  - Instantiated once; reused across cycles.

## Test plan
- WIDTH=8, CHUNK=2, a=8'h3C, b=8'h05, cin=1, sub=0:
  - out_valid exactly 4 cycles after accept.
  - Result: sum=8'h42, cout=0, ovf=0.
- WIDTH=8, CHUNK=2, a=8'h7F, b=8'h01, sub=0:
  - sum=8'h80, cout=0, ovf=1.
  - Then a=8'hFF, b=8'h01: sum=8'h00, cout=1, ovf=0.
- WIDTH=8, CHUNK=2, sub=1:
  - a=8'h05, b=8'h07, cin=1: sum=8'hFE, cout=0, ovf=0 (cin ignored).
  - a=8'h80, b=8'h01: sum=8'h7F, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid stays 1, sum is stable, in_ready stays 0.
  - Toggle a and b during RUN: result unaffected.
  - Raise out_ready: IDLE next cycle.
- Reset:
  - Assert rst_n=0 asynchronously in the second RUN cycle.
  - Immediately: out_valid=0, sum=0, in_ready=1.
  - After release, a fresh op a=8'h10, b=8'h20 gives sum=8'h30.
- Width sweep: WIDTH=32 with CHUNK ∈ {1,8,32}, 200 random operands per config (both modes).
  - sum, cout and ovf match the reference model.
  - Latency equals WIDTH/CHUNK.
